// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Bank of 2**W registers, each B bits wide, with one synchronous write port
//   and one combinational read port. The read path has no bypass. A read of the
//   address being written shows the old contents until the clock edge.
//
// Parameters
//   B       data width in bits (1..64)
//   W       address width in bits (1..8); register count is 2**W
//
// Ports
//   clk     single clock; all state changes on its rising edge
//   rst     synchronous reset, active-low; clears every register and
//           overrides a write issued in the same cycle
//   wr_en   write enable, active-high
//   w_addr  write address
//   w_data  write data
//   r_addr  read address, combinational
//   r_data  contents of register[r_addr]
// -----------------------------------------------------------------------------
module register_file #(
   parameter int B = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] w_addr,
   input  logic [B-1:0] w_data,
   input  logic [W-1:0] r_addr,
   output logic [B-1:0] r_data
);

   localparam int N = 2 ** W;

   logic [B-1:0] regs_q [N];
   logic [B-1:0] regs_d [N];

   // Next state: hold everything, then overwrite only the addressed entry.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_en) begin
         regs_d[w_addr] = w_data;
      end
   end

   // Reset is checked first, so it discards any write issued in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read straight from the registered state, so a same-address write is
   // not forwarded before the clock edge.
   assign r_data = regs_q[r_addr];

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Directed self-checking bench for register_file with B=32, W=4.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled
//   before the next edge.
// -----------------------------------------------------------------------------
module tb_register_file;

   localparam int B = 32;
   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         wr_en;
   logic [W-1:0] w_addr;
   logic [B-1:0] w_data;
   logic [W-1:0] r_addr;
   logic [B-1:0] r_data;

   int total;
   int bad;

   register_file #(.B(B), .W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .w_addr (w_addr),
      .w_data (w_data),
      .r_addr (r_addr),
      .r_data (r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [B-1:0] obs, input logic [B-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h, need 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [W-1:0] a, input logic [B-1:0] d);
      wr_en  = 1'b1;
      w_addr = a;
      w_data = d;
      step();
      wr_en  = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [W-1:0] a, input logic [B-1:0] exp);
      r_addr = a;
      #1;
      check_val(tag, r_data, exp);
   endtask

   logic [B-1:0] exp_seq [8];

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b0;
      wr_en  = 1'b0;
      w_addr = '0;
      w_data = '0;
      r_addr = '0;
      exp_seq = '{32'd1, 32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd15};

      // Reset with rst low for one edge, then sweep every address.
      #2;
      step();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rd_check($sformatf("reset_a%0d", i), W'(i), '0);
      end

      // Write one entry per cycle, then read addresses 0..7.
      wr(4'd0, 32'd1);
      wr(4'd1, 32'd5);
      wr(4'd2, 32'd3);
      wr(4'd7, 32'hF);
      for (int i = 0; i < 8; i++) begin
         rd_check($sformatf("wr_rd_a%0d", i), W'(i), exp_seq[i]);
      end

      // With write disabled, address 1 must keep its value across two edges.
      wr_en  = 1'b0;
      w_addr = 4'd1;
      w_data = 32'hDEADBEEF;
      step();
      step();
      rd_check("wr_dis_a1", 4'd1, 32'd5);

      // Read during a write to the same address: no bypass.
      r_addr = 4'd2;
      wr_en  = 1'b1;
      w_addr = 4'd2;
      w_data = 32'h12345678;
      #1;
      check_val("rdw_before", r_data, 32'd3);
      step();
      wr_en = 1'b0;
      check_val("rdw_after", r_data, 32'h12345678);

      // Two writes to one address: the last value stays.
      wr(4'd3, 32'h11);
      wr(4'd3, 32'h22);
      rd_check("same_addr_last", 4'd3, 32'h22);

      // Reset has no effect before the edge and wins over a same-cycle write.
      r_addr = 4'd7;
      rst    = 1'b0;
      wr_en  = 1'b1;
      w_addr = 4'd7;
      w_data = 32'hAA;
      #1;
      check_val("rst_pre_edge_a7", r_data, 32'hF);
      step();
      rst   = 1'b1;
      wr_en = 1'b0;
      check_val("rst_vs_wr_a7", r_data, 32'h0);
      rd_check("rst_vs_wr_a0", 4'd0, '0);
      rd_check("rst_vs_wr_a1", 4'd1, '0);
      rd_check("rst_vs_wr_a2", 4'd2, '0);

      // Boundary addresses and data patterns.
      wr(4'd14, 32'h5A5A5A5A);
      wr(4'd15, 32'hFFFFFFFF);
      wr(4'd0,  32'h80000001);
      rd_check("bnd_a15", 4'd15, 32'hFFFFFFFF);
      rd_check("bnd_a0",  4'd0,  32'h80000001);
      rd_check("bnd_a14", 4'd14, 32'h5A5A5A5A);
      rd_check("bnd_a1",  4'd1,  32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, need completion");
      $fatal(1);
   end

endmodule
